// File: rtl/ex_mult_unit.sv
// ex_mult_unit: iterative shift-and-add multiplier for the EX stage.
// Produces the low WIDTH bits of op_a*op_b after WIDTH iteration cycles and
// holds the front of the pipeline with stall until the result is presented.
// Vectors are declared [0:WIDTH-1], so bit 0 is the MSB and bit WIDTH-1 the LSB.
module ex_mult_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mul_ex_in,
    input  logic             flush,
    input  logic [0:WIDTH-1] op_a,
    input  logic [0:WIDTH-1] op_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [0:WIDTH-1] multiplicand;
    logic [0:WIDTH-1] multiplier;
    logic [0:WIDTH-1] acc;
    logic [0:WIDTH-1] partial_sum;
    logic [CNT_W-1:0] count;
    logic             start;
    logic             last_iter;

    // A new multiply is accepted only from IDLE and only if it is not being squashed.
    assign start       = (state == IDLE) && mul_ex_in && !flush;
    assign last_iter   = (count == LAST_ITER);
    assign partial_sum = acc + (multiplier[WIDTH-1] ? multiplicand : '0);

    // Stall is combinational so the pipeline freezes in the very cycle the multiply arrives.
    assign stall  = start || (state == BUSY);
    assign result = acc;

    // Next-state logic; flush overrides every transition and returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = BUSY;
            BUSY:    if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    // State register with busy/done registered straight from the next-state decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == BUSY);
            done  <= (next_state == DONE);
        end
    end

    // Operand load on start, one shift-and-add step per BUSY cycle, partial sum dropped on flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            multiplicand <= '0;
            multiplier   <= '0;
            acc          <= '0;
            count        <= '0;
        end else if (start) begin
            multiplicand <= op_a;
            multiplier   <= op_b;
            acc          <= '0;
            count        <= '0;
        end else if (state == BUSY) begin
            if (flush) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc          <= partial_sum;
                multiplicand <= multiplicand << 1;
                multiplier   <= multiplier >> 1;
                count        <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_mult_unit.sv
// tb_ex_mult_unit: self-checking bench for ex_mult_unit.
// Expected values come from a cycle-level model of the pipeline contract
// (stall/busy/done windows relative to the cycle the multiply arrives) and
// from a plain 64-bit product truncated to 32 bits.
module tb_ex_mult_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             mul_ex_in;
    logic             flush;
    logic [0:WIDTH-1] op_a;
    logic [0:WIDTH-1] op_b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [0:WIDTH-1] result;

    int          nAsserts = 0;
    int          nFails = 0;
    logic [31:0] lastResult = '0;
    bit          resultKnown = 1'b0;

    ex_mult_unit #(
        .WIDTH(WIDTH),
        .CNT_W(6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mul_ex_in(mul_ex_in),
        .flush    (flush),
        .op_a     (op_a),
        .op_b     (op_b),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Free-running pipeline clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst, input logic mul, input logic fl,
                                 input logic [31:0] a, input logic [31:0] b);
        reset     = rst;
        mul_ex_in = mul;
        flush     = fl;
        op_a      = a;
        op_b      = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One multiply seen from the pipeline: cycle 0 is the arrival cycle in IDLE.
    // flushAt < 0 means no flush; otherwise flush is raised in that cycle and the
    // instruction is gone from EX afterwards.
    task automatic runMult(input logic [31:0] a, input logic [31:0] b,
                           input bit scramble, input int flushAt);
        logic [63:0] full;
        logic [31:0] expected;
        int          stallCount;
        int          doneCount;
        bit          aborted;
        bit          expStall;
        bit          expBusy;
        bit          expDone;
        full       = 64'(a) * 64'(b);
        expected   = full[31:0];
        stallCount = 0;
        doneCount  = 0;
        for (int k = 0; k <= WIDTH + 1; k++) begin
            aborted = (flushAt >= 0) && (k > flushAt);
            if (k == 0)
                applyStimulus(1'b1, 1'b1, flushAt == 0, a, b);
            else if (aborted)
                applyStimulus(1'b1, 1'b0, 1'b0, $urandom, $urandom);
            else if (scramble)
                applyStimulus(1'b1, 1'b1, k == flushAt, $urandom, $urandom);
            else
                applyStimulus(1'b1, 1'b1, k == flushAt, a, b);
            expStall = !aborted && ((k == 0 && flushAt != 0) || (k >= 1 && k <= WIDTH));
            expBusy  = !aborted && (k >= 1) && (k <= WIDTH);
            expDone  = (flushAt < 0) && (k == WIDTH + 1);
            @(negedge clk);
            checkOutput("stall", 32'(stall), 32'(expStall));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("done", 32'(done), 32'(expDone));
            if (stall) stallCount++;
            if (done) doneCount++;
            if (expDone) checkOutput("result", result, expected);
            @(posedge clk);
            #1;
        end
        if (flushAt < 0) begin
            checkOutput("stall_cycles", stallCount, WIDTH + 1);
            resultKnown = 1'b1;
            lastResult  = expected;
        end else begin
            resultKnown = 1'b0;
        end
        checkOutput("done_pulses", doneCount, (flushAt < 0) ? 1 : 0);
    endtask

    // Cycles with no multiply in EX: everything quiet, finished result held.
    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, $urandom, $urandom);
            @(negedge clk);
            checkOutput("idle_stall", 32'(stall), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("idle_done", 32'(done), 32'd0);
            if (resultKnown) checkOutput("idle_result_hold", result, lastResult);
            @(posedge clk);
            #1;
        end
    endtask

    // Directed sequence followed by randomized multiplies.
    initial begin
        $display("[TB] start");

        applyStimulus(1'b0, 1'b1, 1'b0, 32'd7, 32'd6);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("reset_busy", 32'(busy), 32'd0);
            checkOutput("reset_done", 32'(done), 32'd0);
            checkOutput("reset_result", result, 32'd0);
            @(posedge clk);
            #1;
        end

        runMult(32'd7, 32'd6, 1'b0, -1);
        idleCycles(2);

        runMult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        idleCycles(1);
        runMult(32'h8000_0000, 32'h0000_0002, 1'b0, -1);
        idleCycles(1);
        runMult(32'hFFFF_FFFE, 32'h0000_0003, 1'b0, -1);
        idleCycles(2);

        runMult(32'd3, 32'd5, 1'b0, -1);
        runMult(32'h0001_0000, 32'h0001_0000, 1'b0, -1);
        idleCycles(2);

        runMult(32'd9, 32'd9, 1'b0, 10);
        runMult(32'd2, 32'd2, 1'b0, -1);
        idleCycles(1);

        runMult(32'd55, 32'd66, 1'b0, 0);
        runMult(32'd123, 32'd456, 1'b1, -1);
        idleCycles(1);

        for (int k = 0; k < 40; k++) begin
            if (k <= 5)
                applyStimulus(1'b1, 1'b1, 1'b0, 32'd77, 32'd11);
            else if (k == 6)
                applyStimulus(1'b0, 1'b0, 1'b0, 32'd77, 32'd11);
            else
                applyStimulus(1'b1, 1'b0, 1'b0, 32'd77, 32'd11);
            @(negedge clk);
            checkOutput("rst_abort_busy", 32'(busy), 32'((k >= 1) && (k <= 6)));
            checkOutput("rst_abort_done", 32'(done), 32'd0);
            if (k >= 7) checkOutput("rst_abort_result", result, 32'd0);
            @(posedge clk);
            #1;
        end
        resultKnown = 1'b1;
        lastResult  = '0;

        for (int i = 0; i < 8; i++) begin
            runMult($urandom, $urandom, 1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
